// File: rtl/count_monitor_if.sv
// Counter-side bus of the up/down modulo counter: the counter drives it,
// the monitor only observes it.
interface count_monitor_if #(
  parameter int WIDTH = 4
);
  logic             ENABLE;
  logic             UP_DOWN;
  logic [WIDTH-1:0] COUNT;
  logic             TC;

  modport master (output ENABLE, output UP_DOWN, output COUNT, output TC);
  modport slave  (input  ENABLE, input  UP_DOWN, input  COUNT, input  TC);
endinterface

// File: rtl/count_monitor.sv
// Passive checker for an up/down modulo counter: predicts each COUNT from the
// previous sample, latches the first violation and counts terminal-count events.
module count_monitor #(
  parameter int MODULO    = 10,
  parameter int WIDTH     = 4,
  parameter int EVT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  count_monitor_if.slave       bus,
  input  logic                 CLR_ERR,
  output logic                 SYNCED,
  output logic                 ERROR,
  output logic [1:0]           ERR_CODE,
  output logic [WIDTH-1:0]     EXP_COUNT,
  output logic [WIDTH-1:0]     OBS_COUNT,
  output logic [EVT_WIDTH-1:0] WRAPS
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  typedef enum logic [1:0] {S_SYNC, S_TRACK, S_FAULT} state_t;

  state_t                 r_state, w_next;
  logic [WIDTH-1:0]       r_prev_count;
  logic                   r_prev_en, r_prev_ud;
  logic                   r_error;
  logic [1:0]             r_err_code;
  logic [WIDTH-1:0]       r_exp, r_obs;
  logic [EVT_WIDTH-1:0]   r_wraps;

  logic [WIDTH-1:0]       w_pred;
  logic                   w_range, w_seq, w_tc_exp, w_tc_err, w_viol;
  logic [1:0]             w_code;

  // Wrap is made explicit so a MODULO below 2^WIDTH behaves correctly.
  function automatic logic [WIDTH-1:0] predict(input logic [WIDTH-1:0] c,
                                               input logic en, input logic ud);
    if (!en) return c;
    if (ud)  return (c == MAX_CNT) ? '0 : c + ONE;
    return (c == '0) ? MAX_CNT : c - ONE;
  endfunction

  always_comb begin
    w_pred   = predict(r_prev_count, r_prev_en, r_prev_ud);
    w_range  = ({1'b0, bus.COUNT} >= MOD_EXT);
    w_seq    = (bus.COUNT != w_pred);
    w_tc_exp = bus.ENABLE & ((bus.UP_DOWN & (bus.COUNT == MAX_CNT)) |
                             (~bus.UP_DOWN & (bus.COUNT == '0)));
    w_tc_err = (bus.TC != w_tc_exp);
    w_viol   = w_range | w_seq | w_tc_err;
    if (w_range)       w_code = 2'b11;
    else if (w_seq)    w_code = 2'b01;
    else if (w_tc_err) w_code = 2'b10;
    else               w_code = 2'b00;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_SYNC:  w_next = S_TRACK;
      S_TRACK: if (w_viol) w_next = S_FAULT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_SYNC;
    endcase
    if (CLR_ERR) w_next = S_SYNC;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= S_SYNC;
      r_prev_count <= '0;
      r_prev_en    <= 1'b0;
      r_prev_ud    <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 2'b00;
      r_exp        <= '0;
      r_obs        <= '0;
      r_wraps      <= '0;
    end else begin
      r_state      <= w_next;
      r_prev_count <= bus.COUNT;
      r_prev_en    <= bus.ENABLE;
      r_prev_ud    <= bus.UP_DOWN;
      if (CLR_ERR) begin
        r_error    <= 1'b0;
        r_err_code <= 2'b00;
        r_exp      <= '0;
        r_obs      <= '0;
        r_wraps    <= '0;
      end else if (r_state == S_TRACK) begin
        if (w_viol) begin
          r_error    <= 1'b1;
          r_err_code <= w_code;
          r_exp      <= w_pred;
          r_obs      <= bus.COUNT;
        end else if (bus.TC && (r_wraps != '1)) begin
          r_wraps <= r_wraps + 1'b1;
        end
      end
    end
  end

  assign SYNCED    = (r_state == S_TRACK);
  assign ERROR     = r_error;
  assign ERR_CODE  = r_err_code;
  assign EXP_COUNT = r_exp;
  assign OBS_COUNT = r_obs;
  assign WRAPS     = r_wraps;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor: the bench plays the counter and checks
// the monitor outputs against hand-computed values.
module tb_count_monitor;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       CLR_ERR;
  logic       SYNCED, ERROR;
  logic [1:0] ERR_CODE;
  logic [3:0] EXP_COUNT, OBS_COUNT;
  logic [7:0] WRAPS;

  int n_vec = 0;
  int n_err = 0;

  count_monitor_if #(.WIDTH(4)) bus ();

  count_monitor #(.MODULO(10), .WIDTH(4), .EVT_WIDTH(8)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .bus       (bus.slave),
    .CLR_ERR   (CLR_ERR),
    .SYNCED    (SYNCED),
    .ERROR     (ERROR),
    .ERR_CODE  (ERR_CODE),
    .EXP_COUNT (EXP_COUNT),
    .OBS_COUNT (OBS_COUNT),
    .WRAPS     (WRAPS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one sample to the monitor, clock it, and settle just after the edge.
  task automatic step(input logic en, input logic ud, input logic [3:0] cnt,
                      input logic tc, input logic clr);
    bus.ENABLE  = en;
    bus.UP_DOWN = ud;
    bus.COUNT   = cnt;
    bus.TC      = tc;
    CLR_ERR     = clr;
    @(posedge CLK);
    #1;
  endtask

  // Legal counter sample: TC follows the counter's own combinational rule.
  task automatic cstep(input logic en, input logic ud, input logic [3:0] cnt);
    step(en, ud, cnt, en & ((ud & (cnt == 4'd9)) | (~ud & (cnt == 4'd0))), 1'b0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_synced"}, 32'(SYNCED), 0);
    chk({tag, "_error"},  32'(ERROR), 0);
    chk({tag, "_code"},   32'(ERR_CODE), 0);
    chk({tag, "_exp"},    32'(EXP_COUNT), 0);
    chk({tag, "_obs"},    32'(OBS_COUNT), 0);
    chk({tag, "_wraps"},  32'(WRAPS), 0);
  endtask

  initial begin
    logic [3:0] c;
    RSTn = 1'b0;
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    chk_all_zero("rst");

    // Release and idle: first edge is the baseline, second is a checked hold.
    RSTn = 1'b1;
    cstep(1'b0, 1'b1, 4'd0);
    chk("idle1_synced", 32'(SYNCED), 1);
    chk("idle1_error",  32'(ERROR), 0);
    cstep(1'b0, 1'b1, 4'd0);
    chk("idle2_synced", 32'(SYNCED), 1);
    chk("idle2_error",  32'(ERROR), 0);

    // Count up 0..9,0..3: one TC at 9.
    for (int i = 0; i < 14; i++) cstep(1'b1, 1'b1, 4'(i % 10));
    chk("up_wraps", 32'(WRAPS), 1);
    chk("up_error", 32'(ERROR), 0);
    chk("up_synced", 32'(SYNCED), 1);

    // Count down 4..0: TC at 0 with ENABLE=1, counter then sits at 9.
    for (int i = 4; i >= 0; i--) cstep(1'b1, 1'b0, 4'(i));
    chk("down_wraps", 32'(WRAPS), 2);
    chk("down_error", 32'(ERROR), 0);
    cstep(1'b0, 1'b0, 4'd9);
    cstep(1'b0, 1'b0, 4'd9);
    chk("hold_error", 32'(ERROR), 0);
    chk("hold_wraps", 32'(WRAPS), 2);

    // Walk down to 5, then jump 5 -> 7 counting up.
    cstep(1'b1, 1'b0, 4'd9);
    cstep(1'b1, 1'b0, 4'd8);
    cstep(1'b1, 1'b0, 4'd7);
    cstep(1'b1, 1'b0, 4'd6);
    cstep(1'b1, 1'b1, 4'd5);
    chk("pre_jump_error", 32'(ERROR), 0);
    step(1'b1, 1'b1, 4'd7, 1'b0, 1'b0);
    chk("seq_error",  32'(ERROR), 1);
    chk("seq_code",   32'(ERR_CODE), 1);
    chk("seq_exp",    32'(EXP_COUNT), 6);
    chk("seq_obs",    32'(OBS_COUNT), 7);
    chk("seq_synced", 32'(SYNCED), 0);
    chk("seq_wraps",  32'(WRAPS), 2);
    step(1'b1, 1'b1, 4'd12, 1'b1, 1'b0);
    chk("fault_hold_code",  32'(ERR_CODE), 1);
    chk("fault_hold_exp",   32'(EXP_COUNT), 6);
    chk("fault_hold_obs",   32'(OBS_COUNT), 7);
    chk("fault_hold_wraps", 32'(WRAPS), 2);

    // Clear, resync, then out-of-range COUNT with wrong TC: range wins.
    step(1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
    chk_all_zero("clr1");
    cstep(1'b0, 1'b1, 4'd7);
    chk("resync1_synced", 32'(SYNCED), 1);
    step(1'b1, 1'b1, 4'd12, 1'b1, 1'b0);
    chk("range_error", 32'(ERROR), 1);
    chk("range_code",  32'(ERR_CODE), 3);
    chk("range_exp",   32'(EXP_COUNT), 7);
    chk("range_obs",   32'(OBS_COUNT), 12);
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
    chk("clr2_error",  32'(ERROR), 0);
    chk("clr2_wraps",  32'(WRAPS), 0);
    chk("clr2_synced", 32'(SYNCED), 0);
    cstep(1'b0, 1'b1, 4'd0);
    chk("resync2_synced", 32'(SYNCED), 1);
    chk("resync2_error",  32'(ERROR), 0);

    // Down through 0 (legal TC), then TC=1 at 9 with ENABLE=0.
    cstep(1'b1, 1'b0, 4'd0);
    chk("tc0_wraps", 32'(WRAPS), 1);
    step(1'b0, 1'b0, 4'd9, 1'b1, 1'b0);
    chk("tc_error", 32'(ERROR), 1);
    chk("tc_code",  32'(ERR_CODE), 2);
    chk("tc_exp",   32'(EXP_COUNT), 9);
    chk("tc_obs",   32'(OBS_COUNT), 9);
    chk("tc_wraps", 32'(WRAPS), 1);

    // Asynchronous reset between edges.
    #3 RSTn = 1'b0;
    #1;
    chk_all_zero("async_rst");

    // Long up-count run to drive WRAPS into saturation (260 TC events).
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    RSTn = 1'b1;
    c = 4'd0;
    for (int i = 0; i < 2600; i++) begin
      cstep(1'b1, 1'b1, c);
      c = (c == 4'd9) ? 4'd0 : c + 4'd1;
    end
    chk("sat_wraps",  32'(WRAPS), 255);
    chk("sat_error",  32'(ERROR), 0);
    chk("sat_synced", 32'(SYNCED), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
